// File: rtl/hazard_sched.sv
// Hazard scheduler: load-use and MDU structural stalls, branch squash,
// MDU occupancy tracking and a saturating stall-cycle counter.
module hazard_sched #(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             use_rs_id,
  input  logic             use_rt_id,
  input  logic [4:0]       rd_ex,
  input  logic             lw_ex,
  input  logic             gprwr_ex,
  input  logic             branch_id,
  input  logic             md_start_id,
  input  logic             md_read_id,
  output logic             pc_wr,
  output logic             ifid_wr,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             md_go,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] LAT_M1 = 8'(MDU_LAT - 1);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  state_t     state_nx;
  logic [7:0] mcnt;
  logic [7:0] mcnt_nx;

  logic rs_hit;
  logic rt_hit;
  logic lu;
  logic sh;
  logic stall;
  logic go;

  assign rs_hit = use_rs_id & (rs_id == rd_ex);
  assign rt_hit = use_rt_id & (rt_id == rd_ex);
  assign lu = lw_ex & gprwr_ex & (rd_ex != 5'd0)
            & (rs_hit | rt_hit);

  // A start paired with a read in IDLE is one instruction: no stall.
  assign sh    = (state == BUSY) & (md_start_id | md_read_id);
  assign stall = lu | sh;
  assign go    = md_start_id & (state == IDLE) & ~lu;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      mcnt  <= 8'd0;
    end else begin
      state <= state_nx;
      mcnt  <= mcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    mcnt_nx  = mcnt;
    unique case (state)
      IDLE: begin
        if (go) begin
          state_nx = BUSY;
          mcnt_nx  = LAT_M1;
        end
      end
      BUSY: begin
        if (mcnt == 8'd0) begin
          state_nx = IDLE;
        end else begin
          mcnt_nx = mcnt - 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    pc_wr       = 1'b0;
    ifid_wr     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_go       = 1'b0;
    md_busy     = 1'b0;
    if (clr) begin
      pc_wr       = ~stall;
      ifid_wr     = ~stall;
      ifid_flush  = branch_id & ~stall;
      idex_bubble = stall;
      md_go       = go;
      md_busy     = (state == BUSY);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + ONE;
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: vector table, corner sequences and a
// randomized run against a cycle-count reference model.
module tb_hazard_sched;

  localparam int LAT = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic [4:0]    rs_id, rt_id, rd_ex;
  logic          use_rs_id, use_rt_id;
  logic          lw_ex, gprwr_ex, branch_id;
  logic          md_start_id, md_read_id;
  logic          pc_wr, ifid_wr, ifid_flush;
  logic          idex_bubble, md_go, md_busy;
  logic [CW-1:0] stall_cnt;

  int errs = 0;
  int chks = 0;

  hazard_sched #(.MDU_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr),
    .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
    .rd_ex(rd_ex), .lw_ex(lw_ex), .gprwr_ex(gprwr_ex),
    .branch_id(branch_id),
    .md_start_id(md_start_id), .md_read_id(md_read_id),
    .pc_wr(pc_wr), .ifid_wr(ifid_wr),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .md_go(md_go), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] rd;
    logic       lw;
    logic       wr;
    logic       br;
    logic       st;
    logic       rdm;
    logic [4:0] ex;
  } vec_t;

  vec_t vt[12];

  function automatic logic [4:0] outs();
    return {pc_wr, ifid_wr, ifid_flush, idex_bubble, md_go};
  endfunction

  task automatic chk(string name, int act, int exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic zero_in();
    rs_id = 0; rt_id = 0; rd_ex = 0;
    use_rs_id = 0; use_rt_id = 0;
    lw_ex = 0; gprwr_ex = 0; branch_id = 0;
    md_start_id = 0; md_read_id = 0;
  endtask

  task automatic apply(input vec_t v);
    rs_id = v.rs; rt_id = v.rt;
    use_rs_id = v.urs; use_rt_id = v.urt;
    rd_ex = v.rd; lw_ex = v.lw; gprwr_ex = v.wr;
    branch_id = v.br;
    md_start_id = v.st; md_read_id = v.rdm;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    #2;
    clr = 1'b1;
  endtask

  // reference model state
  int rem;
  int scnt;

  task automatic set_lu(input logic [4:0] r);
    lw_ex = 1; gprwr_ex = 1; rd_ex = r;
    use_rs_id = 1; rs_id = r;
  endtask

  initial begin
    // pc ifid flush bubble go
    vt[0]  = '{5'd8, 5'd0, 1, 0, 5'd8, 1, 1, 0, 0, 0, 5'b00010};
    vt[1]  = '{5'd0, 5'd0, 1, 1, 5'd0, 1, 1, 0, 0, 0, 5'b11000};
    vt[2]  = '{5'd8, 5'd0, 1, 0, 5'd8, 0, 1, 0, 0, 0, 5'b11000};
    vt[3]  = '{5'd0, 5'd9, 1, 0, 5'd9, 1, 1, 0, 0, 0, 5'b11000};
    vt[4]  = '{5'd0, 5'd9, 0, 1, 5'd9, 1, 1, 0, 0, 0, 5'b00010};
    vt[5]  = '{5'd8, 5'd0, 1, 0, 5'd8, 1, 0, 0, 0, 0, 5'b11000};
    vt[6]  = '{5'd1, 5'd2, 1, 1, 5'd3, 1, 1, 1, 0, 0, 5'b11100};
    vt[7]  = '{5'd3, 5'd2, 1, 1, 5'd3, 1, 1, 1, 0, 0, 5'b00010};
    vt[8]  = '{5'd1, 5'd2, 1, 1, 5'd3, 1, 1, 0, 1, 0, 5'b11001};
    vt[9]  = '{5'd3, 5'd2, 1, 1, 5'd3, 1, 1, 0, 1, 0, 5'b00010};
    vt[10] = '{5'd1, 5'd2, 1, 1, 5'd3, 1, 1, 0, 1, 1, 5'b11001};
    vt[11] = '{5'd1, 5'd2, 1, 1, 5'd3, 1, 1, 0, 0, 1, 5'b11000};

    zero_in();
    clr = 1'b0;
    #3;
    chk("rst_outs", int'(outs()), 0);
    chk("rst_busy", int'(md_busy), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    do_reset();

    // combinational vectors from IDLE, reset between each
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      apply(vt[i]);
      #1;
      chk($sformatf("vec%0d", i), int'(outs()), int'(vt[i].ex));
      zero_in();
      do_reset();
    end

    // load-use lasts one cycle
    @(negedge clk);
    set_lu(5'd8);
    #1;
    chk("lu_stall", int'(outs()), 5'b00010);
    @(negedge clk);
    rd_ex = 0; lw_ex = 0; gprwr_ex = 0;
    #1;
    chk("lu_after", int'(pc_wr), 1);
    chk("lu_cnt", int'(stall_cnt), 1);
    zero_in();
    do_reset();

    // MDU occupancy with mfhi right behind
    @(negedge clk);
    md_start_id = 1;
    #1;
    chk("md_go", int'(md_go), 1);
    chk("md_busy_t0", int'(md_busy), 0);
    @(negedge clk);
    md_start_id = 0; md_read_id = 1;
    for (int k = 0; k < LAT; k++) begin
      #1;
      chk($sformatf("md_busy_t%0d", k + 1), int'(md_busy), 1);
      chk($sformatf("md_stall_t%0d", k + 1), int'(outs()), 5'b00010);
      @(negedge clk);
    end
    #1;
    chk("md_free_pc", int'(pc_wr), 1);
    chk("md_free_busy", int'(md_busy), 0);
    chk("md_cnt", int'(stall_cnt), LAT);
    zero_in();
    do_reset();

    // branch held by a load-use stall
    @(negedge clk);
    set_lu(5'd5);
    branch_id = 1;
    #1;
    chk("br_stall_flush", int'(ifid_flush), 0);
    chk("br_stall_bub", int'(idex_bubble), 1);
    @(negedge clk);
    lw_ex = 0; gprwr_ex = 0; rd_ex = 0;
    #1;
    chk("br_late_flush", int'(ifid_flush), 1);
    zero_in();
    do_reset();

    // counter saturation
    @(negedge clk);
    set_lu(5'd7);
    repeat (20) @(negedge clk);
    #1;
    chk("sat_cnt", int'(stall_cnt), (1 << CW) - 1);
    zero_in();
    do_reset();

    // async reset mid-BUSY
    @(negedge clk);
    md_start_id = 1;
    @(negedge clk);
    md_start_id = 0; md_read_id = 1; branch_id = 1;
    #1;
    chk("ar_busy_pre", int'(md_busy), 1);
    @(negedge clk);
    #1;
    chk("ar_cnt_pre", int'(stall_cnt), 1);
    clr = 1'b0;
    #1;
    chk("ar_outs", int'(outs()), 0);
    chk("ar_busy", int'(md_busy), 0);
    chk("ar_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    clr = 1'b1;
    branch_id = 0;
    #1;
    chk("ar_rel_pc", int'(pc_wr), 1);
    chk("ar_rel_busy", int'(md_busy), 0);
    chk("ar_rel_cnt", int'(stall_cnt), 0);
    zero_in();
    do_reset();

    // randomized run against the occupancy model
    rem = 0;
    scnt = 0;
    for (int c = 0; c < 400; c++) begin
      logic b, l, s, st, g;
      @(negedge clk);
      rs_id = 5'($urandom_range(0, 3));
      rt_id = 5'($urandom_range(0, 3));
      rd_ex = 5'($urandom_range(0, 3));
      use_rs_id = 1'($urandom);
      use_rt_id = 1'($urandom);
      lw_ex = ($urandom_range(0, 2) == 0);
      gprwr_ex = ($urandom_range(0, 3) != 0);
      branch_id = ($urandom_range(0, 3) == 0);
      md_start_id = ($urandom_range(0, 3) == 0);
      md_read_id = ($urandom_range(0, 3) == 0);
      #1;
      b = (rem > 0);
      l = lw_ex && gprwr_ex && rd_ex != 0 &&
          ((use_rs_id && rs_id == rd_ex) ||
           (use_rt_id && rt_id == rd_ex));
      s = l || (b && (md_start_id || md_read_id));
      g = md_start_id && !b && !l;
      st = s;
      chk("rnd_outs", int'(outs()),
          int'({!st, !st, branch_id && !st, st, g}));
      chk("rnd_busy", int'(md_busy), int'(b));
      chk("rnd_cnt", int'(stall_cnt), scnt);
      if (st && scnt < (1 << CW) - 1) scnt++;
      if (g) rem = LAT;
      else if (rem > 0) rem--;
    end

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
